fetch_ctrl: RTL

Sequencer for the instruction-fetch stage. Owns the architectural fetch PC, issues one-outstanding instruction-memory requests, buffers returned instructions in a small FIFO toward decode, and handles redirects from execute by flushing the buffer and discarding stale in-flight responses. Sits between the PC-increment datapath, the instruction-memory port and the decode stage.

---
 rtl/fetch_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction-fetch sequencer.
//
// Owns the fetch PC, issues one outstanding instruction-memory request at a
// time, buffers returned instructions in a small FIFO toward decode and
// handles redirects from execute (FIFO flush plus discard of any stale
// in-flight response).
//
// Handshake rule (all interfaces): a transfer happens in a cycle where both
// valid and ready are high at the rising clock edge; valid never waits on
// ready, and payload is held stable while valid is high and ready is low.
//
// Parameters:
//   ENTRY_PC   first PC fetched after reset (low 2 bits must be 0)
//   BUF_DEPTH  instruction FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   redirect_valid, redirect_pc     PC change request from execute
//   mem_req_valid/addr/ready        instruction-memory request channel
//   mem_resp_valid/data             response for the single outstanding request
//   id_valid/instr/pc, id_ready     instruction stream toward decode
//   o_dbg_state                     current FSM state (debug/observability)
//
// Build option:
//   FETCH_BYPASS_EN  when defined, a response arriving while the FIFO is empty
//                    is presented to decode in the same cycle; if decode takes
//                    it, it is never written into the FIFO.

module fetch_ctrl #(
  parameter logic [63:0] ENTRY_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  input  logic        id_ready,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [63:0]       r_pc;
  logic [63:0]       r_req_pc;
  logic [63:0]       r_fifo_pc    [BUF_DEPTH];
  logic [31:0]       r_fifo_instr [BUF_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_can_req;
  logic              w_req_fire;
  logic              w_resp_take;
  logic              w_head_valid;
  logic              w_push;
  logic              w_pop;
  logic [63:0]       w_redirect_pc;

  // Low two bits of the redirect target are ignored (word-aligned fetch).
  assign w_redirect_pc = redirect_pc & ~64'h3;

  // Credit rule: only request when a FIFO slot is guaranteed for the reply.
  assign w_can_req     = (r_count < DEPTH_C);
  assign mem_req_valid = (r_state == S_REQ) && w_can_req;
  assign mem_req_addr  = r_pc;
  assign w_req_fire    = mem_req_valid && mem_req_ready;

  // A response is only kept when it answers a live request in WAIT and no
  // redirect kills it in the same cycle.
  assign w_resp_take   = (r_state == S_WAIT) && mem_resp_valid && !redirect_valid;
  assign w_head_valid  = (r_count != '0);

  // Decode only ever pops from the FIFO head; a redirect suppresses decode.
  assign w_pop         = w_head_valid && !redirect_valid && id_ready;

`ifdef FETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_resp_take && !w_head_valid;
  assign id_valid = (w_head_valid && !redirect_valid) || w_bypass;
  assign id_instr = w_bypass ? mem_resp_data : r_fifo_instr[r_rd_ptr];
  assign id_pc    = w_bypass ? r_req_pc      : r_fifo_pc[r_rd_ptr];
  // A bypassed instruction consumed by decode never occupies a slot.
  assign w_push   = w_resp_take && !(w_bypass && id_ready);
`else
  assign id_valid = w_head_valid && !redirect_valid;
  assign id_instr = r_fifo_instr[r_rd_ptr];
  assign id_pc    = r_fifo_pc[r_rd_ptr];
  assign w_push   = w_resp_take;
`endif

  assign o_dbg_state = r_state;

  // Next-state logic. Redirect has priority; a request accepted or still
  // outstanding at redirect time must have its response drained.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_state_nxt = w_req_fire ? S_DRAIN : S_REQ;
        end else if (w_req_fire) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          w_state_nxt = S_REQ;
        end else if (redirect_valid) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_resp_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_REQ;
      r_pc     <= ENTRY_PC;
      r_req_pc <= ENTRY_PC;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_fire) begin
        r_req_pc <= r_pc;
      end
      if (redirect_valid) begin
        r_pc <= w_redirect_pc;
      end else if (w_req_fire) begin
        r_pc <= r_pc + 64'd4;  // wraps to 0 past the top of the address space
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      // Flush: entries become invalid; contents need not be cleared.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]    <= r_req_pc;
        r_fifo_instr[r_wr_ptr] <= mem_resp_data;
        r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
